sa_conv_sequencer: RTL and testbench

Sequencer for the output-stationary N×N systolic array built from `pe` cells. It accepts a start command with a run-time reduction length, then generates the following for one convolution/matrix tile:

- one array `clear` pulse,
- skewed per-row data and per-column weight feed enables with buffer read indices,
- a result-valid strobe once every accumulator holds its final sum.

It sits between the tile-level controller and the operand buffers / array edge muxes.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_skew_decode.sv | 48 ++++
 rtl/sa_conv_sequencer.sv | 115 +++++++++++
 tb/tb_sa_conv_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array convolution sequencer:
//   - state_e   : sequencer FSM encoding (3-bit)
//   - feed_len  : number of FEED cycles needed for reduction length k on an
//                 n x n array (k + 2(n-1): operand skew across both edges)
// ---------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_FEED = 3'd2,
        ST_DRN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic int unsigned feed_len(input int unsigned k, input int unsigned n);
        return k + 2 * (n - 1);
    endfunction

endpackage

// File: rtl/sa_skew_decode.sv
// ---------------------------------------------------------------------------
// sa_skew_decode
// Purely combinational skew decoder. Lane g (row g and column g) is active
// for feed cycles g <= t < g + klen and then reads buffer element t - g.
// Rows and columns share the same offset, so one lane drives both.
//
// Ports:
//   en_i       : 1      decode enable (high only in FEED)
//   t_i        : TW     feed counter
//   klen_i     : LW     latched reduction length
//   row_vld_o  : N      per-row data valid
//   row_idx_o  : N*IW   per-row data-buffer read index, lane g at [g*IW +: IW]
//   col_vld_o  : N      per-column weight valid
//   col_idx_o  : N*IW   per-column weight-buffer read index
// ---------------------------------------------------------------------------
module sa_skew_decode #(
    parameter int N  = 3,
    parameter int IW = 4,
    parameter int LW = 5,
    parameter int TW = 5
) (
    input  logic            en_i,
    input  logic [TW-1:0]   t_i,
    input  logic [LW-1:0]   klen_i,
    output logic [N-1:0]    row_vld_o,
    output logic [N*IW-1:0] row_idx_o,
    output logic [N-1:0]    col_vld_o,
    output logic [N*IW-1:0] col_idx_o
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam logic [TW-1:0] OFF = TW'(g);

        logic          lane_vld;
        logic [TW-1:0] lane_rel;

        // One extra bit on the upper bound so g + klen cannot wrap.
        assign lane_vld = en_i && (t_i >= OFF) &&
                          ({1'b0, t_i} < ({1'b0, OFF} + (TW+1)'(klen_i)));
        assign lane_rel = t_i - OFF;

        assign row_vld_o[g]           = lane_vld;
        assign col_vld_o[g]           = lane_vld;
        assign row_idx_o[g*IW +: IW]  = lane_vld ? IW'(lane_rel) : '0;
        assign col_idx_o[g*IW +: IW]  = lane_vld ? IW'(lane_rel) : '0;
    end

endmodule

// File: rtl/sa_conv_sequencer.sv
// ---------------------------------------------------------------------------
// sa_conv_sequencer
// Tile sequencer for an output-stationary N x N systolic array of pe cells.
// A start in IDLE latches k_len (clamped to KMAX) and runs
// CLR -> FEED (k_len + 2(N-1) cycles) -> DRN -> DONE -> IDLE.
// All outputs decode from registered state only.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin a tile (sampled in IDLE only)
//   k_len      : LW     reduction length, 0..KMAX (larger values clamp)
//   busy       : high in every state except IDLE
//   arr_clear  : one-cycle accumulator clear for every pe
//   row_vld    : N      row i injects real data
//   row_idx    : N*IW   row i data-buffer index at [i*IW +: IW]
//   col_vld    : N      column j injects real weight
//   col_idx    : N*IW   column j weight-buffer index at [j*IW +: IW]
//   res_vld    : one-cycle pulse, all pe outputs final
//   done       : one-cycle pulse, coincident with res_vld
// ---------------------------------------------------------------------------
module sa_conv_sequencer
    import sa_pkg::*;
#(
    parameter int N    = 3,
    parameter int KMAX = 16,
    parameter int IW   = $clog2(KMAX),
    parameter int LW   = $clog2(KMAX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LW-1:0]   k_len,
    output logic            busy,
    output logic            arr_clear,
    output logic [N-1:0]    row_vld,
    output logic [N*IW-1:0] row_idx,
    output logic [N-1:0]    col_vld,
    output logic [N*IW-1:0] col_idx,
    output logic            res_vld,
    output logic            done
);

    // Feed counter must reach KMAX + 2(N-1) - 1.
    localparam int TW = $clog2(KMAX + 2 * N);

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [LW-1:0] klen_q, klen_d;
    logic [TW-1:0] t_last;

    assign t_last = TW'(feed_len(32'(klen_q), N) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            klen_q  <= klen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        klen_d  = klen_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    klen_d  = (k_len > LW'(KMAX)) ? LW'(KMAX) : k_len;
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                t_d     = '0;
                // Zero-length tile: nothing to feed, accumulators stay cleared.
                state_d = (klen_q == '0) ? ST_DRN : ST_FEED;
            end
            ST_FEED: begin
                if (t_q == t_last) begin
                    state_d = ST_DRN;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_DRN:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign arr_clear = (state_q == ST_CLR);
    assign res_vld   = (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);

    sa_skew_decode #(
        .N  (N),
        .IW (IW),
        .LW (LW),
        .TW (TW)
    ) u_skew (
        .en_i      (state_q == ST_FEED),
        .t_i       (t_q),
        .klen_i    (klen_q),
        .row_vld_o (row_vld),
        .row_idx_o (row_idx),
        .col_vld_o (col_vld),
        .col_idx_o (col_idx)
    );

endmodule

// File: tb/tb_sa_conv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_conv_sequencer
// Directed bench for sa_conv_sequencer (N=3, KMAX=16) with a small 3x3
// output-stationary pe array and operand buffers hung off its outputs.
// ---------------------------------------------------------------------------
module tb_sa_conv_sequencer;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int LW = 5;

    logic            clk;
    logic            rst;
    logic            start;
    logic [LW-1:0]   k_len;
    logic            busy;
    logic            arr_clear;
    logic [N-1:0]    row_vld;
    logic [N*IW-1:0] row_idx;
    logic [N-1:0]    col_vld;
    logic [N*IW-1:0] col_idx;
    logic            res_vld;
    logic            done;

    int total;
    int bad;

    sa_conv_sequencer #(.N(3), .KMAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .arr_clear (arr_clear),
        .row_vld   (row_vld),
        .row_idx   (row_idx),
        .col_vld   (col_vld),
        .col_idx   (col_idx),
        .res_vld   (res_vld),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- operand buffers and 3x3 pe array ----------------
    logic [7:0]  abuf [3][16];
    logic [7:0]  bbuf [3][16];
    logic [7:0]  a_edge [3];
    logic [7:0]  b_edge [3];
    logic [7:0]  a_in [3][3];
    logic [7:0]  b_in [3][3];
    logic [15:0] prod [3][3];
    logic [7:0]  areg [3][3];
    logic [7:0]  breg [3][3];
    logic [7:0]  acc  [3][3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            a_edge[i] = row_vld[i] ? abuf[i][row_idx[i*IW +: IW]] : 8'd0;
            b_edge[i] = col_vld[i] ? bbuf[i][col_idx[i*IW +: IW]] : 8'd0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                a_in[i][j] = (j == 0) ? a_edge[i] : areg[i][j];
                b_in[i][j] = (i == 0) ? b_edge[j] : breg[i][j];
                prod[i][j] = a_in[i][j] * b_in[i][j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    areg[i][j] <= 8'd0;
                    breg[i][j] <= 8'd0;
                    acc[i][j]  <= 8'd0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    acc[i][j] <= arr_clear ? 8'd0 : acc[i][j] + prod[i][j][7:0];
                end
                for (int j = 1; j < 3; j++) begin
                    areg[i][j] <= a_in[i][j-1];
                end
            end
            for (int j = 0; j < 3; j++) begin
                for (int i = 1; i < 3; i++) begin
                    breg[i][j] <= b_in[i-1][j];
                end
            end
        end
    end

    // Output bundle compared as one vector: busy, clr, res, done, rvld, cvld, ridx, cidx
    logic [33:0] obs;
    assign obs = {busy, arr_clear, res_vld, done, row_vld, col_vld, row_idx, col_idx};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++) begin
                case (mode)
                    0: begin abuf[i][k] = 8'd2;  bbuf[i][k] = 8'd3;  end
                    1: begin abuf[i][k] = 8'd16; bbuf[i][k] = 8'd16; end
                    default: begin
                        abuf[i][k] = 8'(k + 1);
                        bbuf[i][k] = 8'((i + 1) * (k + 1));
                    end
                endcase
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; k_len = '0;
        fill(0);
        #3;
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", obs, 34'd0);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got %h want %h", obs, 34'd0);
        end
    endtask

    task automatic test_basic();
        logic [2:0]  ev [12];
        logic [11:0] ei [12];
        logic [33:0] exp_v;
        ev = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b110,
               3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        ei = '{12'h000, 12'h000, 12'h000, 12'h001, 12'h012, 12'h120,
               12'h200, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        k_len = 5'd3; start = 1'b1;
        step();
        start = 1'b0; k_len = 5'd0;   // must not affect the running tile
        for (int c = 1; c <= 11; c++) begin
            exp_v = {c <= 10, c == 1, c == 10, c == 10, ev[c], ev[c], ei[c], ei[c]};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL basic_k3 cycle %0d: got %h want %h", c, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic run_tile_sums(input string nm, input int kl, input logic [71:0] exp_flat);
        int n;
        k_len = LW'(kl); start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!res_vld && n < 60) begin
            step();
            n++;
        end
        total++;
        if (n != kl + 7) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", nm, n, kl + 7);
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                total++;
                if (acc[i][j] !== exp_flat[(i*3+j)*8 +: 8]) begin
                    bad++;
                    $display("FAIL %s_out(%0d,%0d): got %0d want %0d", nm, i, j,
                             acc[i][j], exp_flat[(i*3+j)*8 +: 8]);
                end
            end
        end
        step();
    endtask

    task automatic test_sums();
        fill(0);
        run_tile_sums("sum_2x3", 3, {9{8'd18}});
        fill(1);
        run_tile_sums("sum_wrap", 2, {9{8'd0}});
        fill(2);
        run_tile_sums("sum_ordered", 3, {8'd42, 8'd28, 8'd14, 8'd42, 8'd28, 8'd14,
                                         8'd42, 8'd28, 8'd14});
    endtask

    task automatic test_kzero();
        logic [33:0] exp_v;
        k_len = 5'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp_v = {c <= 3, c == 1, c == 3, c == 3, 30'd0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL kzero cycle %0d: got %h want %h", c, obs, exp_v);
            end
            if (c == 3) begin
                for (int i = 0; i < 3; i++) begin
                    total++;
                    if ({acc[i][0], acc[i][1], acc[i][2]} !== 24'd0) begin
                        bad++;
                        $display("FAIL kzero_outs row %0d: got %h want 0", i,
                                 {acc[i][0], acc[i][1], acc[i][2]});
                    end
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp2;
        k_len = 5'd1; start = 1'b1;
        step();
        for (int c = 1; c <= 27; c++) begin
            exp2 = {c == 1 || c == 10 || c == 19, c == 8 || c == 17 || c == 26};
            total++;
            if ({arr_clear, res_vld} !== exp2) begin
                bad++;
                $display("FAIL b2b cycle %0d: clr/res got %b want %b", c,
                         {arr_clear, res_vld}, exp2);
            end
            if (c == 27) start = 1'b0;
            step();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stop: busy got %b want 0", busy);
        end
    endtask

    task automatic test_ignore_and_clamp();
        int n;
        k_len = 5'd2; start = 1'b1;
        step();
        k_len = 5'd9;
        for (int c = 1; c <= 11; c++) begin
            start = (c <= 9) ? c[0] : 1'b0;
            total++;
            if ({busy, res_vld} !== {c <= 9, c == 9}) begin
                bad++;
                $display("FAIL ignore cycle %0d: busy/res got %b want %b", c,
                         {busy, res_vld}, {c <= 9, c == 9});
            end
            step();
        end
        k_len = 5'd20; start = 1'b1;
        step();
        start = 1'b0; k_len = 5'd0;
        n = 1;
        while (!res_vld && n < 60) begin
            step();
            n++;
        end
        total++;
        if (n != 23) begin
            bad++;
            $display("FAIL clamp_latency: got %0d want 23", n);
        end
        step();
    endtask

    task automatic test_rst_mid();
        fill(0);
        k_len = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();            // cycle 5: FEED, t = 3
        total++;
        if (row_vld !== 3'b110) begin
            bad++;
            $display("FAIL rst_mid_pre: row_vld got %b want 110", row_vld);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL rst_mid_async: got %h want %h", obs, 34'd0);
        end
        step();
        rst = 1'b0;
        total++;
        if (obs !== 34'd0) begin
            bad++;
            $display("FAIL rst_mid_held: got %h want %h", obs, 34'd0);
        end
        run_tile_sums("after_rst", 3, {9{8'd18}});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_sums();
        test_kzero();
        test_back_to_back();
        test_ignore_and_clamp();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
